// File: rtl/mac_dot_pipe.sv
// Pipelined N-channel signed dot-product MAC with optional saturating accumulation.
// One vector pair per cycle, fixed latency of 2 + log2(N) cycles.

module mac_lane #(
    parameter int DW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DW-1:0]     a,
    input  logic [DW-1:0]     b,
    output logic [2*DW-1:0]   p
);
    logic signed [2*DW-1:0] ax, bx;

    assign ax = {{DW{a[DW-1]}}, a};
    assign bx = {{DW{b[DW-1]}}, b};

    always_ff @(posedge clk or negedge reset)
        if (!reset) p <= '0;
        else        p <= ax * bx;
endmodule

module mac_dot_pipe #(
    parameter int N  = 16,
    parameter int DW = 16,
    parameter int OW = 40
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            acc_mode,
    input  logic [N*DW-1:0] a,
    input  logic [N*DW-1:0] b,
    output logic [OW-1:0]   result,
    output logic            valid,
    output logic            ovf,
    output logic            busy
);
    localparam int LG     = $clog2(N);
    localparam int STAGES = LG + 2;
    localparam int TW     = 2*DW + LG;

    logic [STAGES:0]        vld_pipe;
    logic [STAGES-1:0]      mode_pipe;
    logic [N-1:0][2*DW-1:0] prod;

    assign vld_pipe[0]  = start;
    assign mode_pipe[0] = acc_mode;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            vld_pipe[STAGES:1]    <= '0;
            mode_pipe[STAGES-1:1] <= '0;
        end else begin
            vld_pipe[STAGES:1]    <= vld_pipe[STAGES-1:0];
            mode_pipe[STAGES-1:1] <= mode_pipe[STAGES-2:0];
        end

    mac_lane #(.DW(DW)) u_lane [N-1:0] (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .p     (prod)
    );

    // Each tree level halves the node count and widens by one bit, so no overflow.
    for (genvar l = 1; l <= LG; l++) begin : g_lvl
        localparam int NN = N >> l;
        localparam int W  = 2*DW + l;
        logic [2*NN-1:0][W-2:0] src;
        logic [NN-1:0][W-1:0]   sum;

        if (l == 1) begin : g_src
            assign src = prod;
        end else begin : g_src
            assign src = g_lvl[l-1].sum;
        end

        always_ff @(posedge clk or negedge reset)
            if (!reset) sum <= '0;
            else
                for (int i = 0; i < NN; i++)
                    sum[i] <= {src[2*i][W-2], src[2*i]} + {src[2*i+1][W-2], src[2*i+1]};
    end

    logic [TW-1:0] tree_out;
    logic [OW-1:0] acc;
    logic [OW:0]   dot_x, acc_x, tot;
    logic          sat_hi, sat_lo;

    assign tree_out = g_lvl[LG].sum[0];

    // One guard bit above OW makes overflow a simple disagreement of the top two bits.
    always_comb begin
        dot_x  = {{(OW+1-TW){tree_out[TW-1]}}, tree_out};
        acc_x  = mode_pipe[STAGES-1] ? {acc[OW-1], acc} : '0;
        tot    = dot_x + acc_x;
        sat_hi = !tot[OW] &&  tot[OW-1];
        sat_lo =  tot[OW] && !tot[OW-1];
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (vld_pipe[STAGES-1]) begin
            acc <= sat_hi ? {1'b0, {(OW-1){1'b1}}} :
                   sat_lo ? {1'b1, {(OW-1){1'b0}}} : tot[OW-1:0];
            ovf <= sat_hi | sat_lo;
        end else begin
            ovf <= 1'b0;
        end

    assign result = acc;
    assign valid  = vld_pipe[STAGES];
    assign busy   = |vld_pipe[STAGES:1];
endmodule

// File: tb/tb_mac_dot_pipe.sv
// Directed bench for mac_dot_pipe: OW=40 instance plus an OW=36 instance for saturation.

module tb_mac_dot_pipe;
    localparam int N = 16, DW = 16;
    localparam longint P34  = longint'(1) << 34;
    localparam longint MAX2 = (longint'(1) << 35) - 1;
    localparam longint MIN2 = -(longint'(1) << 35);
    localparam longint NEG1 = -longint'(32768) * 32767 * 16;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, acc_mode = 1'b0;
    logic [N*DW-1:0] a = '0, b = '0;
    logic [39:0] r1;
    logic [35:0] r2;
    logic v1, v2, o1, o2, bz1, bz2;

    int total = 0, bad = 0;

    int va[32], vb[32];
    bit vm[32], vr[32], eo2[32];
    longint e1[32], e2[32];

    always #5 clk = ~clk;

    mac_dot_pipe #(.N(N), .DW(DW), .OW(40)) u_dut (
        .clk(clk), .reset(reset), .start(start), .acc_mode(acc_mode), .a(a), .b(b),
        .result(r1), .valid(v1), .ovf(o1), .busy(bz1));

    mac_dot_pipe #(.N(N), .DW(DW), .OW(36)) u_sat (
        .clk(clk), .reset(reset), .start(start), .acc_mode(acc_mode), .a(a), .b(b),
        .result(r2), .valid(v2), .ovf(o2), .busy(bz2));

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int av, input int bv, input bit m, input bit ramp);
        for (int i = 0; i < N; i++) begin
            int t;
            t = ramp ? i + 1 : av;
            a[i*DW +: DW] = t[15:0];
            b[i*DW +: DW] = bv[15:0];
        end
        acc_mode = m;
    endtask

    task automatic set(input int i, input int av, input int bv, input bit m, input bit ramp,
                       input longint x1, input longint x2, input bit xo2);
        va[i] = av; vb[i] = bv; vm[i] = m; vr[i] = ramp;
        e1[i] = x1; e2[i] = x2; eo2[i] = xo2;
    endtask

    // Streams n back-to-back vectors and checks every output cycle by cycle.
    task automatic run_seq(input string nm, input int n);
        for (int t = 0; t < n + 8; t++) begin
            int k;
            if (t < n) begin
                drive(va[t], vb[t], vm[t], vr[t]);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            k = t + 1 - 6;
            chk({nm, "_vld"}, longint'(v1), longint'(k >= 0 && k < n));
            chk({nm, "_vld36"}, longint'(v2), longint'(k >= 0 && k < n));
            chk({nm, "_busy"}, longint'(bz1), longint'(t + 1 - 6 <= n - 1));
            if (k >= 0 && k < n) begin
                chk({nm, "_res"}, longint'($signed(r1)), e1[k]);
                chk({nm, "_ovf"}, longint'(o1), 0);
                chk({nm, "_res36"}, longint'($signed(r2)), e2[k]);
                chk({nm, "_ovf36"}, longint'(o2), longint'(eo2[k]));
            end else begin
                chk({nm, "_ovf_idle"}, longint'(o1 | o2), 0);
            end
        end
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_res", longint'(r1), 0);
        chk("rst_vld", longint'(v1 | v2), 0);
        chk("rst_ovf", longint'(o1 | o2), 0);
        chk("rst_busy", longint'(bz1 | bz2), 0);
        reset = 1'b1;

        set(0, 0, 2, 0, 1, 272, 272, 0);
        run_seq("single", 1);

        for (int k = 0; k < 20; k++) set(k, k, 1, 0, 0, 16 * k, 16 * k, 0);
        run_seq("stream", 20);

        set(0, 1, 1, 0, 0, 16, 16, 0);
        set(1, 1, 1, 1, 0, 32, 32, 0);
        set(2, 1, 1, 1, 0, 48, 48, 0);
        set(3, 1, 1, 1, 0, 64, 64, 0);
        set(4, 1, 1, 0, 0, 16, 16, 0);
        run_seq("accum", 5);

        set(0, -32768, -32768, 0, 0, P34, P34, 0);
        set(1, -32768, 32767, 0, 0, NEG1, NEG1, 0);
        run_seq("extreme", 2);

        drive(1, 1, 0, 0);
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("rstmid_vld", longint'(v1 | v2), 0);
        chk("rstmid_busy", longint'(bz1 | bz2), 0);
        chk("rstmid_res", longint'(r1), 0);
        chk("rstmid_res36", longint'(r2), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            chk("rstmid_noval", longint'(v1 | v2 | bz1), 0);
        end

        set(0, 1, 1, 1, 0, 16, 16, 0);
        run_seq("restart", 1);

        set(0, -32768, -32768, 0, 0, P34, P34, 0);
        set(1, -32768, -32768, 1, 0, 2 * P34, MAX2, 1);
        set(2, -32768, -32768, 1, 0, 3 * P34, MAX2, 1);
        set(3, 0, 0, 1, 0, 3 * P34, MAX2, 0);
        set(4, -1, 1, 1, 0, 3 * P34 - 16, MAX2 - 16, 0);
        run_seq("sat_pos", 5);

        set(0, -32768, 32767, 0, 0, NEG1, NEG1, 0);
        set(1, -32768, 32767, 1, 0, 2 * NEG1, 2 * NEG1, 0);
        set(2, -32768, 32767, 1, 0, 3 * NEG1, MIN2, 1);
        set(3, 0, 0, 1, 0, 3 * NEG1, MIN2, 0);
        run_seq("sat_neg", 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
